// File: rtl/iq_sample_buffer.sv
// iq_sample_buffer: packs 14-bit I/Q pairs into 32-bit words and buffers them
// in a first-word-fall-through FIFO for the packetizer. rd_dr is held off until
// a packet's worth of words is stored, and overflows/underruns are counted.
//
// state  | meaning
// -------+--------------------------------------------------------------
// FILL   | priming; rd_dr=0 until level reaches START_LEVEL
// STREAM | packetizer may pop; rd_dr = FIFO not empty, back to FILL on empty
module iq_sample_buffer #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int START_LEVEL = 367
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [13:0]       sample_i,
  input  logic [13:0]       sample_q,
  input  logic              rd_en,
  output logic [31:0]       rd_data,
  output logic              rd_dr,
  output logic [ADDR_W:0]   level,
  input  logic              clear_stats,
  output logic              overflow,
  output logic [15:0]       overflow_count,
  output logic [15:0]       underrun_count
);

  typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [ADDR_W:0]   LVL_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_START = (ADDR_W+1)'(START_LEVEL);
  localparam logic [ADDR_W:0]   LVL_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic              full, pop, wr_acc, drop;
  state_t            state, state_nxt;
  logic              rd_dr_nxt, underrun_evt;

  // A pop only counts while rd_dr is high; a full FIFO still takes a write
  // when the same cycle pops, so sustained 1-in/1-out never drops at full.
  assign full   = (level == LVL_FULL);
  assign pop    = rd_en & rd_dr;
  assign wr_acc = sample_valid & (~full | pop);
  assign drop   = sample_valid & ~wr_acc;

  assign rd_data = mem[rd_ptr];

  // Post-update occupancy, used by both the level register and the FSM.
  always_comb begin
    level_nxt = level;
    if (wr_acc && !pop)
      level_nxt = level + LVL_ONE;
    else if (!wr_acc && pop)
      level_nxt = level - LVL_ONE;
  end

  // Sample storage; contents are not reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= {2'b00, sample_i, 2'b00, sample_q};
  end

  // Pointers, level, state and registered data-ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      state  <= FILL;
      rd_dr  <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_nxt;
      state <= state_nxt;
      rd_dr <= rd_dr_nxt;
    end
  end

  // Next state and next rd_dr, both judged on the post-update level.
  always_comb begin
    state_nxt    = state;
    rd_dr_nxt    = 1'b0;
    underrun_evt = 1'b0;
    case (state)
      FILL: begin
        if (level_nxt >= LVL_START && level_nxt != '0) begin
          state_nxt = STREAM;
          rd_dr_nxt = 1'b1;
        end
      end
      STREAM: begin
        if (level_nxt == '0) begin
          state_nxt    = FILL;
          underrun_evt = 1'b1;
        end else begin
          rd_dr_nxt = 1'b1;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Statistics; clear_stats takes priority over a coincident event.
  always_ff @(posedge clk) begin
    if (reset || clear_stats) begin
      overflow       <= 1'b0;
      overflow_count <= '0;
      underrun_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
        if (overflow_count != CNT_MAX)
          overflow_count <= overflow_count + 16'd1;
      end
      if (underrun_evt && underrun_count != CNT_MAX)
        underrun_count <= underrun_count + 16'd1;
    end
  end

endmodule
